// File: rtl/xgs_spi_arbiter_if.sv
// xgs_spi_arbiter_if: requester handshakes and SPI master command/response bus
interface xgs_spi_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              host_req, host_rw, host_ack, host_err;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic              seq_req, seq_rw, seq_ack, seq_err;
  logic [ADDR_W-1:0] seq_addr;
  logic [DATA_W-1:0] seq_wdata, seq_rdata;
  logic              spi_start, spi_rw, spi_abort, spi_done;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata, spi_rdata;
  logic              arb_busy;
  modport slave (
    input  host_req, host_rw, host_addr, host_wdata,
    input  seq_req, seq_rw, seq_addr, seq_wdata,
    input  spi_done, spi_rdata,
    output host_ack, host_err, host_rdata,
    output seq_ack, seq_err, seq_rdata,
    output spi_start, spi_rw, spi_addr, spi_wdata, spi_abort, arb_busy
  );
  modport master (
    output host_req, host_rw, host_addr, host_wdata,
    output seq_req, seq_rw, seq_addr, seq_wdata,
    output spi_done, spi_rdata,
    input  host_ack, host_err, host_rdata,
    input  seq_ack, seq_err, seq_rdata,
    input  spi_start, spi_rw, spi_addr, spi_wdata, spi_abort, arb_busy
  );
endinterface

// File: rtl/xgs_spi_arbiter.sv
// xgs_spi_arbiter: shares the XGS SPI master between host and sequencer,
// one transaction at a time, with completion timeout and host anti-starvation.
module xgs_spi_arbiter #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_CONSEC     = 4
) (
  input logic               sys_clk,
  input logic               sys_reset_n,
  xgs_spi_arbiter_if.slave  bus
);
  localparam int CW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int MW = $clog2(MAX_CONSEC + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [MW-1:0]     r_consec;
  logic              r_gnt, r_tmo, r_start, r_abort, r_rw, r_busy;
  logic              r_host_ack, r_seq_ack, r_host_err, r_seq_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_host_rdata, r_seq_rdata;
  logic              w_seq_gnt, w_resp;
  logic [DATA_W-1:0] w_rdata;

  assign w_seq_gnt = bus.seq_req & ~(bus.host_req & (r_consec == MW'(MAX_CONSEC)));
  assign w_resp    = r_tmo | bus.spi_done;
  assign w_rdata   = (r_tmo | ~r_rw) ? '0 : bus.spi_rdata;

  // r_tmo marks the abort cycle so the ack lands one cycle after spi_abort
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_consec     <= '0;
      r_gnt        <= 1'b0;
      r_tmo        <= 1'b0;
      r_start      <= 1'b0;
      r_abort      <= 1'b0;
      r_rw         <= 1'b0;
      r_busy       <= 1'b0;
      r_host_ack   <= 1'b0;
      r_seq_ack    <= 1'b0;
      r_host_err   <= 1'b0;
      r_seq_err    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_host_rdata <= '0;
      r_seq_rdata  <= '0;
    end else begin
      r_start    <= 1'b0;
      r_abort    <= 1'b0;
      r_host_ack <= 1'b0;
      r_seq_ack  <= 1'b0;
      r_host_err <= 1'b0;
      r_seq_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.host_req | bus.seq_req) begin
          r_state  <= S_ISSUE;
          r_busy   <= 1'b1;
          r_start  <= 1'b1;
          r_gnt    <= w_seq_gnt;
          r_rw     <= w_seq_gnt ? bus.seq_rw : bus.host_rw;
          r_addr   <= w_seq_gnt ? bus.seq_addr : bus.host_addr;
          r_wdata  <= w_seq_gnt ? bus.seq_wdata : bus.host_wdata;
          r_consec <= (w_seq_gnt & bus.host_req) ? r_consec + MW'(1) : '0;
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
          r_tmo   <= 1'b0;
        end
        S_WAIT: if (w_resp) begin
          r_state <= S_RESP;
          if (r_gnt) begin
            r_seq_ack   <= 1'b1;
            r_seq_err   <= r_tmo;
            r_seq_rdata <= w_rdata;
          end else begin
            r_host_ack   <= 1'b1;
            r_host_err   <= r_tmo;
            r_host_rdata <= w_rdata;
          end
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 2)) begin
          r_abort <= 1'b1;
          r_tmo   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.spi_start  = r_start;
  assign bus.spi_abort  = r_abort;
  assign bus.spi_rw     = r_rw;
  assign bus.spi_addr   = r_addr;
  assign bus.spi_wdata  = r_wdata;
  assign bus.arb_busy   = r_busy;
  assign bus.host_ack   = r_host_ack;
  assign bus.host_err   = r_host_err;
  assign bus.host_rdata = r_host_rdata;
  assign bus.seq_ack    = r_seq_ack;
  assign bus.seq_err    = r_seq_err;
  assign bus.seq_rdata  = r_seq_rdata;
endmodule

// File: tb/tb_xgs_spi_arbiter.sv
// tb_xgs_spi_arbiter: directed stimulus with a queue-based scoreboard; a monitor
// checks every spi_start command and every requester ack against expectations.
module tb_xgs_spi_arbiter;
  localparam int T = 16;
  typedef struct packed { logic rw; logic [14:0] a; logic [15:0] wd; } cmd_t;
  typedef struct packed { logic who; logic err; logic [15:0] rd; } resp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  xgs_spi_arbiter_if bus ();
  xgs_spi_arbiter #(.ADDR_W(15), .DATA_W(16), .TIMEOUT_CYCLES(T), .MAX_CONSEC(4)) dut (
    .sys_clk(clk), .sys_reset_n(rst_n), .bus(bus)
  );

  int tests = 0, fails = 0;
  cmd_t  q_cmd[$];
  resp_t q_resp[$];
  cmd_t  mc;
  resp_t mr;
  logic [15:0] m_host = '0, m_seq = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues a command or an ack
  always @(negedge clk) begin
    if (!rst_n) begin
      m_host = '0;
      m_seq  = '0;
      q_cmd.delete();
      q_resp.delete();
    end else begin
      if (bus.spi_start) begin
        if (q_cmd.size() == 0) check("unexpected_start", 1, 0);
        else begin
          mc = q_cmd.pop_front();
          check("spi_cmd", {bus.spi_rw, bus.spi_addr, bus.spi_wdata}, mc);
        end
      end
      if (bus.host_ack || bus.seq_ack) begin
        if (q_resp.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          mr = q_resp.pop_front();
          check("ack_who", {bus.host_ack, bus.seq_ack}, mr.who ? 2'b01 : 2'b10);
          check("ack_err", mr.who ? bus.seq_err : bus.host_err, mr.err);
          if (mr.who) m_seq = mr.rd; else m_host = mr.rd;
          check("rdata", {bus.host_rdata, bus.seq_rdata}, {m_host, m_seq});
        end
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0: return bus.spi_start;
      1: return bus.spi_abort;
      default: return bus.host_ack | bus.seq_ack;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int lim, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!sig(w) && n < lim);
  endtask

  task automatic pulse_done(input logic [15:0] rd);
    bus.spi_done  = 1'b1;
    bus.spi_rdata = rd;
    @(posedge clk);
    #1 bus.spi_done = 1'b0;
  endtask

  task automatic expect_txn(input logic who, input logic rw, input logic [14:0] a,
                            input logic [15:0] wd, input logic err, input logic [15:0] rd);
    cmd_t c;
    resp_t r;
    c.rw = rw; c.a = a; c.wd = wd;
    r.who = who; r.err = err; r.rd = (err || !rw) ? 16'h0 : rd;
    q_cmd.push_back(c);
    q_resp.push_back(r);
  endtask

  // dly < 0: SPI master never answers; otherwise spi_done dly cycles after spi_start
  task automatic txn(input logic who, input logic rw, input logic [14:0] a,
                     input logic [15:0] wd, input int dly, input logic [15:0] rd);
    int n;
    if (who) begin bus.seq_req = 1; bus.seq_rw = rw; bus.seq_addr = a; bus.seq_wdata = wd; end
    else begin bus.host_req = 1; bus.host_rw = rw; bus.host_addr = a; bus.host_wdata = wd; end
    expect_txn(who, rw, a, wd, dly < 0, rd);
    wait_sig(0, 10, n);
    check("start_latency", n, 1);
    check("busy", bus.arb_busy, 1);
    if (dly < 0) begin
      wait_sig(1, 64, n);
      check("abort_latency", n, T);
    end else begin
      repeat (dly) @(negedge clk);
      pulse_done(rd);
    end
    wait_sig(2, 64, n);
    check("ack_latency", n, 1);
    check("abort_clear_at_ack", bus.spi_abort, 0);
    check("cmd_hold", {bus.spi_rw, bus.spi_addr, bus.spi_wdata}, {rw, a, wd});
    if (who) bus.seq_req = 0; else bus.host_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic who;
    {bus.host_req, bus.host_rw, bus.host_addr, bus.host_wdata} = '0;
    {bus.seq_req, bus.seq_rw, bus.seq_addr, bus.seq_wdata} = '0;
    {bus.spi_done, bus.spi_rdata} = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.host_ack, bus.seq_ack, bus.host_err, bus.seq_err, bus.host_rdata,
          bus.seq_rdata, bus.spi_start, bus.spi_rw, bus.spi_addr, bus.spi_wdata, bus.spi_abort,
          bus.arb_busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, 0, 15'h3800, 16'h0001, 5, 16'hDEAD);
    @(negedge clk);
    check("idle_after_txn", bus.arb_busy, 0);
    txn(0, 1, 15'h3001, 16'h0000, 1, 16'h1234);
    @(negedge clk);
    txn(1, 1, 15'h3E0E, 16'h0000, 2, 16'hA5C3);
    @(negedge clk);
    // Both requesters held: seq x4 then host, twice
    for (int i = 0; i < 10; i++) begin
      who = (i % 5 == 4) ? 1'b0 : 1'b1;
      expect_txn(who, 0, who ? 15'h0100 : 15'h0200, who ? 16'h1111 : 16'h2222, 0, 16'h0);
    end
    bus.seq_req = 1; bus.seq_rw = 0; bus.seq_addr = 15'h0100; bus.seq_wdata = 16'h1111;
    bus.host_req = 1; bus.host_rw = 0; bus.host_addr = 15'h0200; bus.host_wdata = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      wait_sig(0, 20, n);
      check("rr_start_seen", n < 20, 1);
      @(negedge clk);
      pulse_done(16'hFFFF);
      wait_sig(2, 20, n);
      check("rr_ack_latency", n, 1);
    end
    bus.seq_req = 0; bus.host_req = 0;
    @(negedge clk);
    txn(0, 1, 15'h3000, 16'h0000, -1, 16'h0);
    @(negedge clk);
    txn(1, 0, 15'h3010, 16'hBEEF, 3, 16'h7777);
    @(negedge clk);
    txn(0, 1, 15'h3020, 16'h0000, T - 1, 16'h4321);
    @(negedge clk);
    // Reset during WAIT drops the transaction with no ack
    bus.host_req = 1; bus.host_rw = 0; bus.host_addr = 15'h3802; bus.host_wdata = 16'h00AA;
    expect_txn(0, 0, 15'h3802, 16'h00AA, 0, 16'h0);
    wait_sig(0, 10, n);
    check("pre_reset_start", n, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {bus.host_ack, bus.seq_ack, bus.host_err, bus.seq_err,
          bus.host_rdata, bus.seq_rdata, bus.spi_start, bus.spi_rw, bus.spi_addr, bus.spi_wdata,
          bus.spi_abort, bus.arb_busy}, 0);
    bus.host_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", bus.arb_busy, 0);
    txn(0, 0, 15'h3804, 16'h5A5A, 1, 16'h0);
    repeat (3) @(negedge clk);
    check("queues_empty", q_cmd.size() + q_resp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
